// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared size encodings, FSM state type and defaults for the LSU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam int c_mem_words_default = 206;

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;
  localparam logic [1:0] c_size_ill  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      c_size_byte: size_aligned = 1'b1;
      c_size_half: size_aligned = ~lane[0];
      c_size_word: size_aligned = (lane == 2'b00);
      default:     size_aligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module : lsu_lane_align
// Brief  : Little-endian lane extract/extend for loads, lane merge for stores.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = mem_word[{lane, 3'b000} +: 8];
    w_half = mem_word[{lane[1], 4'b0000} +: 16];

    case (size)
      c_size_byte: load_data = is_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      c_size_half: load_data = is_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default:     load_data = mem_word;
    endcase

    // Untouched lanes keep the current memory contents.
    merged_word = mem_word;
    case (size)
      c_size_byte: merged_word[{lane, 3'b000} +: 8]     = wdata[7:0];
      c_size_half: merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default:     merged_word = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Single-outstanding load/store unit for a word-wide data memory.
//          Byte/half accesses exist only when LSU_SUBWORD_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = c_mem_words_default
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  lsu_state_t  r_state;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
`ifdef LSU_SUBWORD_EN
  logic        r_we;
`endif

  logic        w_accept;
  logic        w_size_ok;
  logic        w_range_ok;
  logic        w_err;
  logic        w_idle;
  logic [1:0]  w_sel_size;
  logic [1:0]  w_sel_lane;
  logic [31:0] w_sel_wdata;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_idle    = (r_state == ST_IDLE);
  assign req_ready = w_idle;
  assign w_accept  = req_valid && w_idle;

  always_comb begin
    w_range_ok = ({2'b00, req_addr[31:2]} < 32'(MEM_WORDS));
`ifdef LSU_SUBWORD_EN
    w_size_ok  = size_aligned(req_size, req_addr[1:0]);
`else
    w_size_ok  = (req_size == c_size_word) && size_aligned(req_size, req_addr[1:0]);
`endif
    w_err      = ~(w_size_ok && w_range_ok);
  end

  // In IDLE the aligner sees the incoming request so word stores merge to req_wdata.
  assign w_sel_size  = w_idle ? req_size       : r_size;
  assign w_sel_lane  = w_idle ? req_addr[1:0]  : r_lane;
  assign w_sel_wdata = w_idle ? req_wdata      : r_wdata;

  lsu_lane_align u_lane_align (
    .size        (w_sel_size),
    .is_unsigned (r_unsigned),
    .lane        (w_sel_lane),
    .mem_word    (mem_dout),
    .wdata       (w_sel_wdata),
    .load_data   (w_load_data),
    .merged_word (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_size     <= c_size_word;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= 32'h0;
`ifdef LSU_SUBWORD_EN
      r_we       <= 1'b0;
`endif
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_din    <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
`ifdef LSU_SUBWORD_EN
            r_we       <= req_we;
`endif
            mem_addr   <= {2'b00, req_addr[31:2]};
            resp_rdata <= 32'h0;
            if (w_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              r_state    <= ST_RESP;
            end else if (req_we && req_size == c_size_word) begin
              mem_din <= w_merged;
              mem_we  <= 1'b1;
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
`ifdef LSU_SUBWORD_EN
          if (r_we) begin
            mem_din <= w_merged;
            mem_we  <= 1'b1;
            r_state <= ST_WRITE;
          end else
`endif
          begin
            resp_rdata <= w_load_data;
            resp_valid <= 1'b1;
            r_state    <= ST_RESP;
          end
        end
        ST_WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed + random bench for load_store_unit against a byte-level
//          reference model of the attached memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int MEM_WORDS = 206;
`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        preload = 1'b0;
  int          we_count = 0;
  logic [31:0] last_we_addr = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // Asynchronous-read memory: word is valid at the edge after mem_addr is driven.
  assign mem_dout = (mem_addr < MEM_WORDS) ? mem[mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      we_count     = we_count + 1;
      last_we_addr = mem_addr;
      if (mem_addr < MEM_WORDS) mem[mem_addr] <= mem_din;
    end
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
    end
  endtask

  // Reference: byte-granular arithmetic on ref_mem, updating it for stores.
  function automatic void model(input bit we, input bit [1:0] size, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wdata,
                                output bit err, output bit [31:0] rdata, output int lat);
    int unsigned idx, off, nbytes;
    bit [31:0] mask, v;
    idx    = addr >> 2;
    off    = addr % 4;
    nbytes = 1 << size;
    err    = (size == 2'b11) || (!SUBWORD && size != 2'b10) ||
             (addr % nbytes != 0) || (idx >= MEM_WORDS);
    rdata  = 32'h0;
    mask   = 32'((64'd1 << (8 * nbytes)) - 64'd1);
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = (ref_mem[idx] >> (8 * off)) & mask;
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      rdata = v;
      lat   = 2;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      lat = (nbytes == 4) ? 2 : 3;
    end
  endfunction

  task automatic do_req(input string tag, input bit we, input bit [1:0] size, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wdata);
    bit        exp_err;
    bit [31:0] exp_rd;
    int        exp_lat, lat, we0;
    int unsigned idx;
    model(we, size, uns, addr, wdata, exp_err, exp_rd, exp_lat);
    idx = addr >> 2;
    @(negedge clk);
    check(tag, "req_ready", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    we0 = we_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 8);
    check(tag, "latency", lat, exp_lat);
    check(tag, "resp_rdata", resp_rdata, exp_rd);
    check(tag, "resp_err", {31'h0, resp_err}, {31'h0, exp_err});
    check(tag, "we_pulses", we_count - we0, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err) check(tag, "we_addr", last_we_addr, idx);
    if (idx < MEM_WORDS) check(tag, "mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    bit        e;
    bit [31:0] rd, a, hold;
    int        l, lat, we0;
    bit [1:0]  sz;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'h8899AABB;
    preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;

    // Reset state
    check("reset", "req_ready", {31'h0, req_ready}, 32'd1);
    check("reset", "resp_valid", {31'h0, resp_valid}, 32'd0);
    check("reset", "resp_rdata", resp_rdata, 32'h0);
    check("reset", "resp_err", {31'h0, resp_err}, 32'd0);
    check("reset", "mem_we", {31'h0, mem_we}, 32'd0);
    check("reset", "mem_addr", mem_addr, 32'h0);
    check("reset", "mem_din", mem_din, 32'h0);
    @(negedge clk) reset = 1'b0;

    do_req("ld_b_signed", 1'b0, 2'b00, 1'b0, 32'h16, 32'h0);
    do_req("ld_h_unsigned", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
    do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFF11);
    do_req("ld_w_after_st", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    do_req("ld_w_misalign", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    do_req("ld_w_range", 1'b0, 2'b10, 1'b0, 32'h338, 32'h0);
    do_req("ld_w_last", 1'b0, 2'b10, 1'b0, 32'h334, 32'h0);
    do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    do_req("st_h", 1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234);
    do_req("ld_w_after_sth", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    do_req("size_ill", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);

    // Response back-pressure
    a = 32'h40;
    model(1'b0, 2'b10, 1'b0, a, 32'h0, e, rd, l);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = a;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 8);
    check("stall", "resp_valid", {31'h0, resp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall", "hold_valid", {31'h0, resp_valid}, 32'd1);
      check("stall", "hold_rdata", resp_rdata, rd);
      check("stall", "hold_ready", {31'h0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall", "ready_after", {31'h0, req_ready}, 32'd1);
    check("stall", "valid_after", {31'h0, resp_valid}, 32'd0);

    // Reset while a sub-word store is in flight
    hold = mem[5];
    we0  = we_count;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h15;
    req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid", "req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_mid", "resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_mid", "mem_we", {31'h0, mem_we}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid", "we_pulses", we_count - we0, 0);
    check("rst_mid", "mem_word", mem[5], hold);
    do_req("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = $urandom_range(MEM_WORDS * 4, MEM_WORDS * 4 + 64);
      else
        a = $urandom_range(0, MEM_WORDS * 4 - 1);
      if ($urandom_range(0, 1) == 1 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      do_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 206, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  access request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned, out-of-range or illegal-size access.
REQ-015 SHALL have port mem_addr  output  32  word index into data memory, equal to latched req_addr>>2.
REQ-016 SHALL have port mem_din  output  32  word written to memory.
REQ-017 SHALL have port mem_we  output  1  memory write enable.
REQ-018 SHALL have port mem_dout  input  32  memory read word; valid at the posedge after mem_addr is driven.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL latch request fields on the posedge where req_valid and req_ready are both 1.
REQ-021 SHALL flag error if req_size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr>>2 >= MEM_WORDS; error requests go IDLE->RESP with no memory access and resp_err=1.
REQ-022 SHALL route loads IDLE->READ->RESP; word stores IDLE->WRITE->RESP; sub-word stores IDLE->READ->WRITE->RESP.
REQ-023 SHALL assert mem_we for exactly one cycle, in WRITE only; mem_we=0 in all other states.
REQ-024 SHALL use little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
REQ-025 SHALL for loads extract the selected lane from mem_dout sampled at end of READ and extend per req_unsigned (word loads unchanged).
REQ-026 SHALL for sub-word stores merge req_wdata low bits into the selected lane of mem_dout, preserving other lanes, into mem_din.
REQ-027 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready=1, then return to IDLE; request acceptance resumes the following cycle.
REQ-028 SHALL give load latency 2 cycles (accept to resp_valid), word store 2, sub-word store 3, error 1, with resp_ready held high.

Reset
REQ-029 SHALL on reset force IDLE asynchronously, drive resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-030 SHALL drop any in-flight request on reset mid-operation; no memory write occurs after reset asserts.

Configuration
REQ-031 SHALL honour macro LSU_SUBWORD_EN: defined -> byte/half accesses per REQ-022..026; undefined -> any req_size other than 10 treated as error per REQ-021, and the READ->WRITE path is absent.

Structure
REQ-032 SHALL place size encodings, FSM state enum and MEM_WORDS default in shared package lsu_pkg.
REQ-033 SHALL place lane extract/extend/merge logic in combinational sub-module lsu_lane_align.

Verification
REQ-034 SHALL cover: memory word 5 = 0x8899AABB, load byte addr 0x16 signed -> resp_rdata 0xFFFFFF99 two cycles after accept, resp_err 0.
REQ-035 SHALL cover: same word, load half addr 0x16 unsigned -> resp_rdata 0x00008899.
REQ-036 SHALL cover: store byte 0x11 to addr 0x15 -> single mem_we pulse, mem_addr 5, mem_din 0x889911BB; later word load addr 0x14 returns 0x889911BB.
REQ-037 SHALL cover: load word addr 0x06 and load word addr 0x338 (word 206) -> resp_err 1, resp_rdata 0, mem_we never asserted, response one cycle after accept.
REQ-038 SHALL cover: resp_ready held 0 for 4 cycles -> resp_valid/data stable, req_ready 0 throughout; accept next request the cycle after resp_ready=1.
REQ-039 SHALL cover: reset asserted during READ of a sub-word store -> IDLE immediately, mem_we stays 0, target word unchanged.
